// File: rtl/life_sequencer.sv
// Conway's Life generation sequencer for an 8x8 non-wrapping board.
// Snapshots the board, then streams the next generation out one row per cycle.
module life_sequencer #(
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             run,
    input  logic             tick,
    input  logic [7:0]       period,
    input  logic [63:0]      cells,
    output logic             write,
    output logic [2:0]       row_select,
    output logic [7:0]       row_val,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic [1:0]       state_dbg
);

    // Handshake: a start is accepted only on an edge where busy=0 and step=1
    // (or the tick timer expires); requests seen while busy=1 are dropped.
    typedef enum logic [1:0] {IDLE = 2'd0, SNAP = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] snap;
    logic [2:0]  row;
    logic [7:0]  tick_cnt;
    logic [8:0]  eff_period;
    logic        expire;
    logic        start;

    // Next value of row r, with the board padded by dead rows/columns on all sides.
    function automatic logic [7:0] next_row(input logic [63:0] b, input logic [2:0] r);
        logic [79:0] pad;
        logic [9:0]  above;
        logic [9:0]  cur;
        logic [9:0]  below;
        logic [3:0]  n;
        logic [7:0]  res;
        int          ri;
        pad   = {8'd0, b, 8'd0};
        ri    = int'(r);
        above = {1'b0, pad[8*ri +: 8], 1'b0};
        cur   = {1'b0, pad[8*(ri+1) +: 8], 1'b0};
        below = {1'b0, pad[8*(ri+2) +: 8], 1'b0};
        res   = 8'd0;
        for (int c = 0; c < 8; c++) begin
            n = 4'd0;
            for (int d = 0; d < 3; d++) begin
                n = n + {3'b0, above[c+d]} + {3'b0, below[c+d]};
            end
            n = n + {3'b0, cur[c]} + {3'b0, cur[c+2]};
            res[c] = (n == 4'd3) || (cur[c+1] && (n == 4'd2));
        end
        return res;
    endfunction

    assign eff_period = (period == 8'd0) ? 9'd1 : {1'b0, period};
    assign expire     = (state == IDLE) && run && tick && (({1'b0, tick_cnt} + 9'd1) >= eff_period);
    assign start      = (state == IDLE) && (step || expire);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SNAP;
            SNAP:    state_next = WRITE;
            WRITE:   if (row == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap      <= 64'd0;
            row       <= 3'd0;
            gen_count <= '0;
            tick_cnt  <= 8'd0;
        end else begin
            if (state == SNAP) begin
                snap <= cells;
                row  <= 3'd0;
            end else if (state == WRITE) begin
                row <= row + 3'd1;
            end
            if (state == DONE) begin
                gen_count <= gen_count + {{(GEN_W-1){1'b0}}, 1'b1};
            end
            // Timer holds while busy; an expiry always coincides with a start.
            if (!run || start) begin
                tick_cnt <= 8'd0;
            end else if ((state == IDLE) && tick) begin
                tick_cnt <= tick_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        write      = 1'b0;
        row_select = 3'd0;
        row_val    = 8'd0;
        if (state == WRITE) begin
            write      = 1'b1;
            row_select = row;
            row_val    = next_row(snap, row);
        end
        busy      = (state != IDLE);
        done      = (state == DONE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: table of boards with expected next generations,
// plus hand-written auto-step, ignored-request and mid-write reset sequences.
module tb_life_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic        run;
    logic        tick;
    logic [7:0]  period;
    logic [63:0] cells;
    logic        write;
    logic [2:0]  row_select;
    logic [7:0]  row_val;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic [1:0]  state_dbg;

    typedef struct {
        logic [63:0] board;
        logic [63:0] next_gen;
        string       name;
    } vec_t;

    vec_t        vecs[8];
    logic [10:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          n_writes = 0;
    int          n_done = 0;
    logic [15:0] exp_gen = 16'd0;

    localparam logic [63:0] BLINKER = 64'h0000_0000_1C00_0000;

    life_sequencer #(.GEN_W(16)) dut (
        .clk(clk), .reset(reset), .step(step), .run(run), .tick(tick),
        .period(period), .cells(cells), .write(write), .row_select(row_select),
        .row_val(row_val), .busy(busy), .done(done), .gen_count(gen_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: explicit neighbour count with bounds tests.
    function automatic logic [63:0] life_model(input logic [63:0] b);
        logic [63:0] res;
        int n;
        res = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < 8) &&
                            (c + dc >= 0) && (c + dc < 8) && b[(r + dr) * 8 + c + dc]) n++;
                    end
                end
                res[r * 8 + c] = (n == 3) || (b[r * 8 + c] && n == 2);
            end
        end
        return res;
    endfunction

    task automatic push_rows(input logic [63:0] e);
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), e[8*i +: 8]});
    endtask

    always @(negedge clk) begin
        if (write) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=row%0d/%0h required=no write", row_select, row_val);
            end else begin
                check("row_write", {row_select, row_val}, exp_q.pop_front());
            end
        end else begin
            check("idle_outputs", {row_select, row_val}, 64'd0);
        end
        if (done) n_done++;
    end

    task automatic wait_done(input string name);
        int g = 0;
        while (!done && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({name, "_done"}, done, 1);
        @(negedge clk);
        exp_gen++;
        check({name, "_gen_count"}, gen_count, exp_gen);
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic run_step(input logic [63:0] c, input logic [63:0] e, input string name);
        @(negedge clk);
        cells = c;
        step  = 1'b1;
        push_rows(e);
        @(negedge clk);
        step = 1'b0;
        check({name, "_snap_busy"}, busy, 1);
        check({name, "_snap_write"}, write, 0);
        @(negedge clk);
        cells = {$urandom, $urandom};
        repeat (7) @(negedge clk);
        @(negedge clk);
        check({name, "_done_at_k10"}, done, 1);
        check({name, "_busy_at_k10"}, busy, 1);
        @(negedge clk);
        exp_gen++;
        check({name, "_done_clear"}, done, 0);
        check({name, "_busy_clear"}, busy, 0);
        check({name, "_gen_count"}, gen_count, exp_gen);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 0);
    endtask

    task automatic auto_gens(input logic [7:0] p, input int ngen);
        int need, cnt, phase, got, guard;
        bit fire, probe;
        need = (p == 8'd0) ? 1 : int'(p);
        cells = BLINKER;
        period = p;
        run = 1'b1;
        cnt = 0; phase = 0; got = 0; guard = 0; fire = 0; probe = 0;
        while (got < ngen && guard < 400) begin
            @(negedge clk);
            guard++;
            tick = 1'b0;
            if (fire) begin
                check("auto_snap_after_tick", busy, 1);
                check("auto_snap_no_write", write, 0);
                fire = 0;
                cnt = 0;
                wait_done("auto");
                got++;
                continue;
            end
            if (probe) begin
                check("auto_no_early_start", busy, 0);
                probe = 0;
            end
            if (phase % 4 == 0) begin
                tick = 1'b1;
                if (!busy) begin
                    cnt++;
                    if (cnt == need) begin
                        fire = 1;
                        push_rows(64'h0000_0008_0808_0000);
                    end else begin
                        probe = 1;
                    end
                end
            end
            phase++;
        end
        check("auto_gens_completed", 64'(got), 64'(ngen));
        @(negedge clk);
        tick = 1'b0;
        run = 1'b0;
    endtask

    initial begin
        int w0, d0, g;
        reset = 1'b1; step = 1'b0; run = 1'b0; tick = 1'b0; period = 8'd0; cells = 64'd0;

        vecs[0] = '{BLINKER, 64'h0000_0008_0808_0000, "blinker"};
        vecs[1] = '{64'h0000_0000_0000_0303, 64'h0000_0000_0000_0303, "corner_block"};
        vecs[2] = '{64'h0000_0000_0000_0001, 64'h0, "isolated"};
        vecs[3] = '{64'h0, 64'h0, "empty"};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8100_0000_0000_0081, "full"};
        for (int i = 5; i < 8; i++) begin
            vecs[i].board = {$urandom, $urandom};
            vecs[i].next_gen = life_model(vecs[i].board);
            vecs[i].name = $sformatf("random%0d", i);
        end

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_write", write, 0);
        check("reset_gen_count", gen_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_done", done, 0);
        check("post_reset_state", state_dbg, 0);

        for (int i = 0; i < 8; i++) run_step(vecs[i].board, vecs[i].next_gen, vecs[i].name);

        auto_gens(8'd3, 2);
        auto_gens(8'd0, 2);

        // Requests while busy are dropped.
        w0 = n_writes; d0 = n_done;
        run = 1'b1; period = 8'd1;
        @(negedge clk);
        cells = BLINKER; step = 1'b1;
        push_rows(64'h0000_0008_0808_0000);
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        step = 1'b1; tick = 1'b1;
        @(negedge clk);
        step = 1'b0; tick = 1'b0;
        wait_done("ignored");
        repeat (5) @(negedge clk);
        check("ignored_write_count", 64'(n_writes - w0), 8);
        check("ignored_done_count", 64'(n_done - d0), 1);
        check("ignored_no_restart", busy, 0);
        run = 1'b0;

        // Reset in the middle of WRITE.
        @(negedge clk);
        cells = BLINKER; step = 1'b1;
        push_rows(64'h0000_0008_0808_0000);
        @(negedge clk);
        step = 1'b0;
        g = 0;
        while (!(write && row_select == 3'd4) && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("midreset_reached_row4", row_select, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_write", write, 0);
        check("midreset_busy", busy, 0);
        check("midreset_gen_count", gen_count, 0);
        exp_q.delete();
        exp_gen = 16'd0;
        repeat (3) @(negedge clk);
        check("midreset_no_resume", busy, 0);
        run_step(BLINKER, 64'h0000_0008_0808_0000, "after_reset");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/life_sequencer.md
LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 Parameter GEN_W, default 16: width of the generation counter.
REQ-002 clk  input  1  system clock; all logic updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 step  input  1  single-generation request, sampled every cycle.
REQ-005 run  input  1  auto-step enable.
REQ-006 tick  input  1  timebase pulse for auto-step.
REQ-007 period  input  8  number of ticks between auto generations; 0 is treated as 1.
REQ-008 cells  input  64  current board state; row r = cells[8r+7:8r], bit c = column c.
REQ-009 write  output  1  board row-write strobe.
REQ-010 row_select  output  3  row being written.
REQ-011 row_val  output  8  next-generation value for row_select.
REQ-012 busy  output  1  high while a generation is in progress.
REQ-013 done  output  1  one-cycle pulse when a generation completes.
REQ-014 gen_count  output  GEN_W  number of completed generations.

Function
REQ-015 The FSM SHALL have states IDLE, SNAP, WRITE and DONE.
REQ-016 Transitions SHALL be: IDLE->SNAP on a start condition; SNAP->WRITE unconditionally; WRITE->DONE after row 7 is written; DONE->IDLE unconditionally.
REQ-017 The start condition in IDLE SHALL be step=1, or run=1 with the tick timer expired.
REQ-018 In SNAP, the block SHALL latch cells into an internal 64-bit snapshot; all next-generation values SHALL be computed from this snapshot only.
REQ-019 In WRITE, the block SHALL hold write=1 for exactly 8 consecutive cycles, with row_select stepping 0,1,...,7, one row per cycle.
REQ-020 row_val SHALL follow Conway rules on the snapshot:
- a live cell with 2 or 3 live neighbours stays live;
- a dead cell with exactly 3 live neighbours becomes live;
- every other cell becomes or stays dead.
REQ-021 The board SHALL NOT wrap: neighbours outside rows 0-7 or columns 0-7 count as dead.
REQ-022 Outside WRITE, write, row_select and row_val SHALL all be 0.
REQ-023 Latency, with the start sampled at edge k:
- SNAP during cycle k+1;
- WRITE during cycles k+2..k+9;
- done=1 during cycle k+10;
- busy=1 during cycles k+1..k+10;
- a new start is accepted from edge k+11.
REQ-024 gen_count SHALL increment by 1 on the edge that leaves DONE, wrapping from all-ones to 0.
REQ-025 Tick timer:
- counts tick pulses only while in IDLE with run=1;
- expires when the count reaches max(period,1);
- clears to 0 on expiry, on any start, and whenever run=0.
REQ-026 A step and a timer expiry in the same cycle SHALL start exactly one generation and clear the timer.
REQ-027 step and tick pulses received while busy=1 SHALL be ignored and not queued.
REQ-028 A change of period mid-count SHALL take effect at the next comparison; if the count is already at or above the new value, the timer expires on the next tick.

Reset
REQ-029 When reset=1 is sampled, the next state SHALL be IDLE, and write, row_select, row_val, busy, done, gen_count, the tick timer and the snapshot SHALL all be 0.
REQ-030 Reset SHALL take priority over every other input, including in the middle of WRITE; the remaining rows of an interrupted generation SHALL NOT be written and gen_count SHALL NOT increment.

Verification
REQ-031 Blinker: cells row3=8'b00011100, other rows 0, pulse step -> rows 2, 3 and 4 written as 8'b00001000, other rows written as 0; done at k+10; gen_count=1.
REQ-032 Corner block: rows 0 and 1 = 8'b00000011, other rows 0, pulse step -> all 8 rows rewritten unchanged (edge cells counted as dead).
REQ-033 Auto-step: run=1, period=3, tick every 4th cycle -> SNAP entered one cycle after the 3rd tick; after two generations, gen_count=2. Repeat with period=0 -> a generation starts after every tick.
REQ-034 Ignored requests: step pulsed at k, then step and tick pulsed at k+4 -> exactly 8 writes, one done pulse, gen_count=1.
REQ-035 Reset mid-operation: reset asserted when row_select=4 -> next cycle write=0, busy=0, gen_count=0; a following step produces a full 8-row sequence starting at row 0.
REQ-036 Isolated cell: single live cell at row 0 bit 0 -> all rows written as 0.
